frame_loader_4ch: RTL
=====================

Name: frame_loader_4ch

Overview:
Upstream staging stage for the registered 4:1 channel mux. It accepts a serial sample stream with a valid/ready handshake and packs every 4 consecutive samples into a frame. Frames are double-buffered (ping-pong), so one bank fills while the other is presented on four parallel channel outputs. It also generates the 2-bit `sel` sequence that the mux uses to read the presented frame back out, one channel per cycle.

Parameters:
WIDTH, 16, sample width in bits (matches the mux data width)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
in_data  input  WIDTH  serial sample
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader can accept a sample this cycle
hold  input  1  downstream stall; freezes readout sequencing
outA  output  WIDTH  frame sample 0 (first accepted)
outB  output  WIDTH  frame sample 1
outC  output  WIDTH  frame sample 2
outD  output  WIDTH  frame sample 3 (last accepted)
sel  output  2  channel select for the downstream mux
frame_valid  output  1  a frame is being read out
out_last  output  1  high while sel==3 and frame_valid==1

Behaviour:
- Reset (rst=1 at a posedge) sets:
  - outA..outD = 0, sel = 0, frame_valid = 0, out_last = 0;
  - write count = 0, write-bank-full flag = 0, reader = IDLE.
  - A partial frame, pending frame, or in-progress readout is discarded.
  - in_ready = 0 while rst is high and 1 in the first cycle after.
- Accept rule: a sample is taken when in_valid && in_ready at a posedge. in_ready = !wr_full, decoded combinationally from registered state.
- Write side:
  - The write count runs 0..3 and selects the write-bank slot; the count-0 sample goes to slot A.
  - When the slot-3 sample is accepted (cycle N), the count wraps to 0.
  - If a swap is allowed at N, the banks swap at N. Otherwise wr_full=1 and in_ready=0 until the swap.
- Swap allowed when the reader is IDLE, or when the reader is READ with sel==3 and hold==0 (last channel completing).
  - A swap at a posedge makes the new frame visible on outA..outD in the next cycle, with frame_valid=1 and sel=0.
  - A pending full bank swaps at the first allowed posedge. wr_full clears there, and in_ready=1 in the following cycle.
- Reader FSM:
  - IDLE: frame_valid=0, sel=0; outA..outD hold the last frame. Goes to READ on a swap.
  - READ:
    - hold=0: sel increments each cycle.
    - sel==3 and hold=0: on a swap, sel goes to 0 and READ continues back-to-back with no bubble; with no swap, the FSM goes to IDLE.
    - hold=1: sel, frame_valid and the outputs are frozen; the write side still accepts samples until wr_full.
- Throughput: sustained 1 sample/cycle with hold=0 never deasserts in_ready.
- Latency: the 4th sample is accepted at N; outA..outD are valid with sel=0 at N+1. The mux output for channel k appears at N+2+k, because the mux adds one register stage.
- Simultaneous events:
  - A swap-allowed cycle plus a new 4th-sample acceptance swaps that sample's bank.
  - rst takes priority over everything.

Test Plan:
- Single frame: after reset, send 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles with hold=0. Required: the cycle after the 4th, outA..D = 1, 2, 3, 4, frame_valid=1; sel steps 0, 1, 2, 3; out_last only at sel=3; then frame_valid=0, sel=0, outputs held.
- Back-to-back: 12 samples 0x0010..0x001B at full rate. Required:
  - three consecutive frames with frame_valid continuously 1 for 12 cycles;
  - sel cycles 0..3 three times;
  - in_ready never 0.
- Input gaps: 4 samples with in_valid low for 2 cycles between each. Required: the frame presents only after the 4th acceptance, and the values are intact.
- Backpressure: hold=1 from the first READ cycle for 10 cycles while 8 more samples stream in. Required:
  - sel frozen at 0;
  - after 4 accepts wr_full makes in_ready=0 and further samples are not taken;
  - after hold drops, readout completes, the frame swaps in with no bubble, and in_ready returns to 1.
- Reset mid-operation: rst during READ at sel=2 with 2 samples in the write bank. Required:
  - all outputs are 0 the next cycle;
  - the partial frame is lost;
  - the next 4 samples form a clean frame in slots A..D.
- Simultaneous: the 4th sample arrives exactly when sel==3 with hold=0. Required: the swap happens in that cycle, sel=0 with the new data the next cycle, and in_ready stays 1.

Source files
------------

// File: rtl/frame_loader_4ch_if.sv
// frame_loader_4ch_if: sample-stream handshake, four-channel frame outputs and mux select
interface frame_loader_4ch_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic hold;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic [WIDTH-1:0] outC;
  logic [WIDTH-1:0] outD;
  logic [1:0] sel;
  logic frame_valid;
  logic out_last;
  modport master (output in_data, in_valid, hold, input in_ready, outA, outB, outC, outD, sel, frame_valid, out_last);
  modport slave (input in_data, in_valid, hold, output in_ready, outA, outB, outC, outD, sel, frame_valid, out_last);
endinterface

// File: rtl/frame_loader_4ch.sv
// frame_loader_4ch: packs 4 serial samples into ping-pong frames and sequences the mux select
module frame_loader_4ch #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  frame_loader_4ch_if.slave bus
);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic wr_full;
  logic [WIDTH-1:0] wbuf [4];
  logic acc, last_acc, rd_done, swap;
  assign bus.in_ready = !wr_full && !rst;
  assign acc = bus.in_valid && bus.in_ready;
  assign last_acc = acc && cnt == 2'd3;
  assign rd_done = state == READ && bus.sel == 2'd3 && !bus.hold;
  // A full bank (stored or completing this cycle) moves out once the reader is free
  assign swap = (state == IDLE || rd_done) && (wr_full || last_acc);
  assign bus.frame_valid = state == READ;
  assign bus.out_last = state == READ && bus.sel == 2'd3;
  // Reader next state: a swap always (re)starts a readout, otherwise finishing returns to idle
  always_comb begin
    state_n = swap ? READ : rd_done ? IDLE : state;
  end
  // Write bank storage; acc is already blocked during reset
  always_ff @(posedge clk) begin
    if (acc) wbuf[cnt] <= bus.in_data;
  end
  // Write count, bank-full flag, presented frame and select sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      wr_full <= 1'b0;
      bus.sel <= 2'd0;
      bus.outA <= '0;
      bus.outB <= '0;
      bus.outC <= '0;
      bus.outD <= '0;
    end else begin
      state <= state_n;
      if (acc) cnt <= cnt + 2'd1;
      wr_full <= swap ? 1'b0 : last_acc ? 1'b1 : wr_full;
      bus.sel <= swap ? 2'd0 : (state == READ && !bus.hold) ? bus.sel + 2'd1 : bus.sel;
      if (swap) begin
        bus.outA <= wbuf[0];
        bus.outB <= wbuf[1];
        bus.outC <= wbuf[2];
        bus.outD <= wr_full ? wbuf[3] : bus.in_data;
      end
    end
  end
endmodule
